// File: rtl/voter_pkg.sv
// Purpose : shared widths, vote weights and derived shift amounts for the voter_plus tally.
// Latency : n/a (constants only).
// Backpres: n/a (no flow control in this block family).
package voter_pkg;

    // Panel sizes and result width
    localparam int NP_W   = 32;
    localparam int VIP_W  = 8;
    localparam int RES_W  = 8;

    // Vote weights; all are powers of two so the weighting is a plain shift
    localparam int W_NP   = 1;
    localparam int W_VIP  = 4;
    localparam int W_VVIP = 16;

    localparam int SH_NP   = $clog2(W_NP);
    localparam int SH_VIP  = $clog2(W_VIP);
    localparam int SH_VVIP = $clog2(W_VVIP);

    // Popcount output widths
    localparam int NP_CW  = $clog2(NP_W + 1);
    localparam int VIP_CW = $clog2(VIP_W + 1);

    // Max total is 32*1 + 8*4 + 16 = 80, which fits in 7 bits
    localparam int SUM_W  = 7;

endpackage : voter_pkg

// File: rtl/voter_plus_popcount.sv
// Purpose : combinational population count of an N-bit vector.
// Latency : 0 cycles (pure combinational).
// Backpres: none; output follows input continuously.
//
// Ports:
//   bits  - N-bit input vector
//   count - number of set bits, $clog2(N+1) wide
module popcount #(
    parameter int N = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : popcount

// File: rtl/voter_plus.sv
// Purpose : weighted one-shot vote tally (32 normal x1, 8 VIP x4, 1 VVIP x16); each vote latched once until reset.
// Latency : vote high at edge k appears in result just after edge k; reset clears result asynchronously.
// Backpres: none; inputs are sampled every edge, no handshake.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high clear of all latched votes
//   np     - normal voter inputs, one bit per voter
//   vip    - VIP voter inputs, one bit per voter
//   vvip   - VVIP voter input
//   result - weighted total of latched votes, driven from the flags only
module voter_plus
    import voter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NP_W-1:0]    np,
    input  logic [VIP_W-1:0]   vip,
    input  logic               vvip,
    output logic [RES_W-1:0]   result
);

    // Sticky vote flags
    logic [NP_W-1:0]  np_voted;
    logic [VIP_W-1:0] vip_voted;
    logic             vvip_voted;

    // Set-only: OR-ing in the inputs makes a held-high voter count exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            np_voted   <= '0;
            vip_voted  <= '0;
            vvip_voted <= 1'b0;
        end else begin
            np_voted   <= np_voted  | np;
            vip_voted  <= vip_voted | vip;
            vvip_voted <= vvip_voted | vvip;
        end
    end

    // Per-class counts
    logic [NP_CW-1:0]  np_cnt;
    logic [VIP_CW-1:0] vip_cnt;

    popcount #(.N(NP_W)) u_np_count (
        .bits  (np_voted),
        .count (np_cnt)
    );

    popcount #(.N(VIP_W)) u_vip_count (
        .bits  (vip_voted),
        .count (vip_cnt)
    );

    // Weighted adder: every term is zero-extended to SUM_W before shifting,
    // so no weighted term can lose its top bits.
    logic [SUM_W-1:0] np_term;
    logic [SUM_W-1:0] vip_term;
    logic [SUM_W-1:0] vvip_term;
    logic [SUM_W-1:0] total;

    always_comb begin
        np_term   = SUM_W'(np_cnt)     << SH_NP;
        vip_term  = SUM_W'(vip_cnt)    << SH_VIP;
        vvip_term = SUM_W'(vvip_voted) << SH_VVIP;
        total     = np_term + vip_term + vvip_term;
    end

    assign result = RES_W'(total);

endmodule : voter_plus

// File: tb/tb_voter_plus.sv
// Purpose : directed table-driven check of voter_plus plus hand-written async-reset and glitch sequences.
// Latency : inputs driven on falling edge, result sampled 1ns after the rising edge.
// Backpres: n/a.
module tb_voter_plus;

    logic        clk;
    logic        reset;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [7:0]  result;

    int n_checks = 0;
    int n_fail   = 0;

    voter_plus dut (
        .clk    (clk),
        .reset  (reset),
        .np     (np),
        .vip    (vip),
        .vvip   (vvip),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        logic [7:0]  exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [7:0] exp);
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL %s: result=%0d expected=%0d", name, result, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] n, input logic [7:0] v, input logic vv);
        reset = r;
        np    = n;
        vip   = v;
        vvip  = vv;
    endtask

    initial begin
        // {reset, np, vip, vvip, expected result after the edge}
        vecs[0]  = '{1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1, 8'd0};   // reset dominates inputs
        vecs[1]  = '{1'b1, 32'h0000_1234, 8'h81, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd0};   // released, idle
        vecs[3]  = '{1'b0, 32'h0000_86F7, 8'h0F, 1'b0, 8'd26};  // 10 + 16
        vecs[4]  = '{1'b0, 32'h0000_FFFF, 8'hFF, 1'b1, 8'd64};  // union: 16 + 32 + 16
        vecs[5]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd64};  // inputs dropped, sticky
        vecs[6]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd64};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 8'd80};  // full house
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 8'd80};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 8'd80};
        vecs[10] = '{1'b1, 32'h0000_0000, 8'h00, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16};  // vvip held 5 edges
        vecs[12] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16};
        vecs[13] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16};
        vecs[14] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16};
        vecs[15] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16};
        vecs[16] = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'd16};
        vecs[17] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'd16};  // re-vote ignored

        // Reset from time zero with busy inputs: result must be 0 before any edge.
        drive(1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1);
        #1;
        check("reset_t0", 8'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].np, vecs[i].vip, vecs[i].vvip);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Build up to 64 again (vvip already latched), then async reset between edges.
        @(negedge clk);
        drive(1'b0, 32'h0000_FFFF, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        check("rebuild_64", 8'd64);
        #2;
        drive(1'b0, 32'h0, 8'h00, 1'b0);
        reset = 1'b1;                   // mid-cycle, no edge yet
        #1;
        check("async_reset_immediate", 8'd0);

        // Inputs active during reset across an edge must not leak in.
        np = 32'hFFFF_FFFF; vip = 8'hFF; vvip = 1'b1;
        @(posedge clk);
        #1;
        check("reset_held_edge", 8'd0);

        @(negedge clk);
        drive(1'b0, 32'h0, 8'h00, 1'b0);
        #1;
        check("reset_release_idle", 8'd0);

        @(negedge clk);
        vip = 8'h01;
        @(posedge clk);
        #1;
        check("vip_single", 8'd4);

        // Pulse that rises and falls between edges is ignored.
        vip = 8'h00;
        #2;
        np = 32'h0000_0001;
        #2;
        np = 32'h0;
        @(posedge clk);
        #1;
        check("glitch_ignored", 8'd4);

        // Single high-order normal voter and a second VIP.
        @(negedge clk);
        np = 32'h8000_0000; vip = 8'h80;
        @(posedge clk);
        #1;
        check("np_msb_vip_msb", 8'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_voter_plus
